load_resp: RTL and testbench

LOAD_RESP -- requirements
Module: load_resp

---
 rtl/load_resp_if.sv | 32 +++
 rtl/load_resp.sv | 131 +++++++++++++
 tb/tb_load_resp.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/load_resp_if.sv
// Load response bundle: request issue, memory return and result handshake.
// master = load issuer / memory / consumer side, slave = load_resp buffer.
interface load_resp_if #(
    parameter int TAG_WIDTH = 5
);
    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           req_size;
    logic [1:0]           req_offset;
    logic                 req_signed;
    logic [TAG_WIDTH-1:0] req_tag;
    logic                 mem_valid;
    logic [31:0]          mem_rdata;
    logic                 res_valid;
    logic                 res_ready;
    logic [31:0]          res_data;
    logic [TAG_WIDTH-1:0] res_tag;
    logic                 res_err;
    logic                 ovf_err;

    modport master (
        output req_valid, req_size, req_offset, req_signed, req_tag,
        output mem_valid, mem_rdata, res_ready,
        input  req_ready, res_valid, res_data, res_tag, res_err, ovf_err
    );

    modport slave (
        input  req_valid, req_size, req_offset, req_signed, req_tag,
        input  mem_valid, mem_rdata, res_ready,
        output req_ready, res_valid, res_data, res_tag, res_err, ovf_err
    );
endinterface

// File: rtl/load_resp.sv
// Outstanding-load buffer: queues load requests, extracts/extends the
// in-order memory responses, and hands results back in issue order.
// Ports: clk, rst_n (async active-low), bus (load_resp_if.slave):
//   req_*  issue handshake, mem_* response strobe (no backpressure),
//   res_*  result handshake, ovf_err sticky unexpected-response flag.
// Option: define LOAD_RESP_MISALIGN_CHECK_EN to flag misaligned
//   half/word loads (res_err=1, res_data=0).
module load_resp #(
    parameter int DEPTH_LOG2 = 2,
    parameter int TAG_WIDTH  = 5
) (
    input logic        clk,
    input logic        rst_n,
    load_resp_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = DEPTH[DEPTH_LOG2:0];

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;

    ptr_t alloc_ptr, fill_ptr, ret_ptr;
    cnt_t count, pend;
    logic [DEPTH-1:0] filled;
    logic             ovf_q;

    logic [1:0]           size_q [DEPTH];
    logic [1:0]           off_q  [DEPTH];
    logic                 sgn_q  [DEPTH];
    logic [TAG_WIDTH-1:0] tag_q  [DEPTH];
    logic [31:0]          data_q [DEPTH];
`ifdef LOAD_RESP_MISALIGN_CHECK_EN
    logic                 err_q  [DEPTH];
    logic                 ext_err;
`endif

    logic        accept, do_fill, retire;
    logic [31:0] ext_data;

    function automatic logic [31:0] extract(
        input logic [1:0]  sz,
        input logic [1:0]  off,
        input logic        sgn,
        input logic [31:0] w
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        unique case (sz)
            2'd0:    r = {{24{sgn & b[7]}}, b};
            2'd1:    r = {{16{sgn & h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    assign accept  = bus.req_valid & bus.req_ready;
    // Pending (allocated but unfilled) count gates responses; an accept in
    // the same cycle is not yet visible to the fill side.
    assign do_fill = bus.mem_valid & (pend != '0);
    assign retire  = bus.res_valid & bus.res_ready;

    always_comb begin
        ext_data = extract(size_q[fill_ptr], off_q[fill_ptr],
                           sgn_q[fill_ptr], bus.mem_rdata);
`ifdef LOAD_RESP_MISALIGN_CHECK_EN
        ext_err = 1'b0;
        if ((size_q[fill_ptr] == 2'd1 && off_q[fill_ptr][0]) ||
            (size_q[fill_ptr][1] && off_q[fill_ptr] != 2'd0)) begin
            ext_err  = 1'b1;
            ext_data = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            ret_ptr   <= '0;
            count     <= '0;
            pend      <= '0;
            filled    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (accept)
                alloc_ptr <= alloc_ptr + ptr_t'(1);
            if (do_fill) begin
                fill_ptr         <= fill_ptr + ptr_t'(1);
                filled[fill_ptr] <= 1'b1;
            end
            if (retire) begin
                ret_ptr         <= ret_ptr + ptr_t'(1);
                filled[ret_ptr] <= 1'b0;
            end
            if (bus.mem_valid && pend == '0)
                ovf_q <= 1'b1;
            count <= count + cnt_t'(accept) - cnt_t'(retire);
            pend  <= pend + cnt_t'(accept) - cnt_t'(do_fill);
        end
    end

    // Payload storage needs no reset: it is only observed behind filled.
    always_ff @(posedge clk) begin
        if (accept) begin
            size_q[alloc_ptr] <= bus.req_size;
            off_q[alloc_ptr]  <= bus.req_offset;
            sgn_q[alloc_ptr]  <= bus.req_signed;
            tag_q[alloc_ptr]  <= bus.req_tag;
        end
        if (do_fill) begin
            data_q[fill_ptr] <= ext_data;
`ifdef LOAD_RESP_MISALIGN_CHECK_EN
            err_q[fill_ptr]  <= ext_err;
`endif
        end
    end

    assign bus.req_ready = (count < DEPTH_C);
    assign bus.res_valid = filled[ret_ptr];
    assign bus.res_data  = bus.res_valid ? data_q[ret_ptr] : '0;
    assign bus.res_tag   = bus.res_valid ? tag_q[ret_ptr] : '0;
`ifdef LOAD_RESP_MISALIGN_CHECK_EN
    assign bus.res_err   = bus.res_valid & err_q[ret_ptr];
`else
    assign bus.res_err   = 1'b0;
`endif
    assign bus.ovf_err   = ovf_q;
endmodule

// File: tb/tb_load_resp.sv
// Directed bench for load_resp: extraction vector table plus
// hand sequences for full buffer, ordering, overflow and reset.
module tb_load_resp;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    load_resp_if #(.TAG_WIDTH(5)) bus ();

    load_resp #(.DEPTH_LOG2(2), .TAG_WIDTH(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]  size;
        logic [1:0]  off;
        logic        sgn;
        logic [31:0] rdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid  = 1'b0;
        bus.req_size   = 2'd0;
        bus.req_offset = 2'd0;
        bus.req_signed = 1'b0;
        bus.req_tag    = '0;
        bus.mem_valid  = 1'b0;
        bus.mem_rdata  = '0;
        bus.res_ready  = 1'b0;
    endtask

    task automatic issue(input logic [1:0] sz, input logic [1:0] off,
                         input logic sgn, input logic [4:0] tag);
        bus.req_valid  = 1'b1;
        bus.req_size   = sz;
        bus.req_offset = off;
        bus.req_signed = sgn;
        bus.req_tag    = tag;
        tick();
        bus.req_valid  = 1'b0;
    endtask

    task automatic respond(input logic [31:0] w);
        bus.mem_valid = 1'b1;
        bus.mem_rdata = w;
        tick();
        bus.mem_valid = 1'b0;
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
        chk({tag, "_res_data"},  bus.res_data,       32'd0);
        chk({tag, "_res_tag"},   32'(bus.res_tag),   32'd0);
        chk({tag, "_res_err"},   32'(bus.res_err),   32'd0);
        chk({tag, "_ovf_err"},   32'(bus.ovf_err),   32'd0);
    endtask

    initial begin
        vecs[0]  = '{2'd1, 2'd0, 1'b0, 32'h788EFD0C, 32'h0000FD0C, 1'b0};
        vecs[1]  = '{2'd1, 2'd0, 1'b1, 32'h788EFD0C, 32'hFFFFFD0C, 1'b0};
        vecs[2]  = '{2'd1, 2'd2, 1'b1, 32'h788EFD0C, 32'h0000788E, 1'b0};
        vecs[3]  = '{2'd0, 2'd2, 1'b1, 32'h788EFD0C, 32'hFFFFFF8E, 1'b0};
        vecs[4]  = '{2'd0, 2'd0, 1'b1, 32'h788EFD0C, 32'h0000000C, 1'b0};
        vecs[5]  = '{2'd2, 2'd0, 1'b1, 32'h788EFD0C, 32'h788EFD0C, 1'b0};
        vecs[6]  = '{2'd0, 2'd1, 1'b0, 32'h788EFD0C, 32'h000000FD, 1'b0};
        vecs[7]  = '{2'd0, 2'd1, 1'b1, 32'h788EFD0C, 32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{2'd0, 2'd3, 1'b1, 32'h788EFD0C, 32'h00000078, 1'b0};
        vecs[9]  = '{2'd3, 2'd0, 1'b0, 32'h788EFD0C, 32'h788EFD0C, 1'b0};
        vecs[10] = '{2'd1, 2'd0, 1'b1, 32'h12348000, 32'hFFFF8000, 1'b0};
        vecs[11] = '{2'd0, 2'd1, 1'b1, 32'h12348000, 32'hFFFFFF80, 1'b0};
`ifdef LOAD_RESP_MISALIGN_CHECK_EN
        vecs[12] = '{2'd1, 2'd1, 1'b0, 32'h788EFD0C, 32'h00000000, 1'b1};
        vecs[13] = '{2'd2, 2'd2, 1'b0, 32'h788EFD0C, 32'h00000000, 1'b1};
`else
        vecs[12] = '{2'd1, 2'd1, 1'b0, 32'h788EFD0C, 32'h0000FD0C, 1'b0};
        vecs[13] = '{2'd2, 2'd2, 1'b0, 32'h788EFD0C, 32'h788EFD0C, 1'b0};
`endif

        idle();
        #3;
        reset_outputs("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // Extraction table: one load at a time.
        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].size, vecs[i].off, vecs[i].sgn, 5'(i + 10));
            respond(vecs[i].rdata);
            chk($sformatf("v%0d_valid", i), 32'(bus.res_valid), 32'd1);
            chk($sformatf("v%0d_data", i), bus.res_data, vecs[i].exp_data);
            chk($sformatf("v%0d_err", i), 32'(bus.res_err),
                32'(vecs[i].exp_err));
            chk($sformatf("v%0d_tag", i), 32'(bus.res_tag), 32'(i + 10));
            bus.res_ready = 1'b1;
            tick();
            bus.res_ready = 1'b0;
            chk($sformatf("v%0d_drain", i), 32'(bus.res_valid), 32'd0);
        end

        // Fill to capacity with results held, then drain in order.
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("fill_rdy%0d", i), 32'(bus.req_ready), 32'd1);
            issue(2'd2, 2'd0, 1'b0, 5'(i));
        end
        chk("full_req_ready", 32'(bus.req_ready), 32'd0);
        for (int i = 1; i <= 4; i++)
            respond(32'h100 + 32'(i));
        tick();
        chk("held_valid", 32'(bus.res_valid), 32'd1);
        chk("held_tag", 32'(bus.res_tag), 32'd1);
        chk("held_data", bus.res_data, 32'h101);
        bus.res_ready = 1'b1;
        chk("pre_retire_rdy", 32'(bus.req_ready), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("order_tag%0d", i), 32'(bus.res_tag), 32'(i));
            chk($sformatf("order_data%0d", i), bus.res_data,
                32'h100 + 32'(i));
            tick();
            if (i == 1)
                chk("post_retire_rdy", 32'(bus.req_ready), 32'd1);
        end
        bus.res_ready = 1'b0;
        chk("drained_valid", 32'(bus.res_valid), 32'd0);

        // Full buffer: retire and request in the same cycle.
        for (int i = 5; i <= 8; i++)
            issue(2'd2, 2'd0, 1'b0, 5'(i));
        for (int i = 5; i <= 8; i++)
            respond(32'h200 + 32'(i));
        bus.req_valid  = 1'b1;
        bus.req_size   = 2'd2;
        bus.req_offset = 2'd0;
        bus.req_tag    = 5'd9;
        bus.res_ready  = 1'b1;
        #1;
        chk("full_same_rdy", 32'(bus.req_ready), 32'd0);
        chk("full_same_tag", 32'(bus.res_tag), 32'd5);
        tick();
        bus.res_ready = 1'b0;
        chk("next_rdy", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        chk("refull_rdy", 32'(bus.req_ready), 32'd0);
        bus.res_ready = 1'b1;
        for (int i = 6; i <= 8; i++) begin
            chk($sformatf("b_tag%0d", i), 32'(bus.res_tag), 32'(i));
            tick();
        end
        bus.res_ready = 1'b0;
        chk("b_wait_valid", 32'(bus.res_valid), 32'd0);
        respond(32'hCAFE0009);
        chk("b_tag9", 32'(bus.res_tag), 32'd9);
        chk("b_data9", bus.res_data, 32'hCAFE0009);
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk("b_empty", 32'(bus.res_valid), 32'd0);
        chk("b_empty_rdy", 32'(bus.req_ready), 32'd1);
        chk("b_no_ovf", 32'(bus.ovf_err), 32'd0);

        // Reset mid-operation discards loads; late response overflows.
        issue(2'd2, 2'd0, 1'b0, 5'd20);
        issue(2'd2, 2'd0, 1'b0, 5'd21);
        rst_n = 1'b0;
        #1;
        reset_outputs("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        respond(32'h12345678);
        chk("ovf_set", 32'(bus.ovf_err), 32'd1);
        chk("ovf_no_valid", 32'(bus.res_valid), 32'd0);
        tick();
        tick();
        tick();
        chk("ovf_sticky", 32'(bus.ovf_err), 32'd1);
        chk("ovf_still_no_valid", 32'(bus.res_valid), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ovf_clear", 32'(bus.ovf_err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
